// File: rtl/load_pulse_pkg.sv
// Shared definitions for pushbutton front-ends.
//   - FSM state encodings (3-bit) for the debounce / load-strobe state machine.
//   - Default debounce and auto-repeat intervals in system clock cycles.
package load_pulse_pkg;

  localparam int unsigned DefaultDebounceCycles = 50000;
  localparam int unsigned DefaultRepeatCycles   = 25000000;

  localparam logic [2:0] StIdleEnc       = 3'd0;
  localparam logic [2:0] StDebPressEnc   = 3'd1;
  localparam logic [2:0] StPulseEnc      = 3'd2;
  localparam logic [2:0] StHeldEnc       = 3'd3;
  localparam logic [2:0] StDebReleaseEnc = 3'd4;

  typedef enum logic [2:0] {
    StIdle       = StIdleEnc,
    StDebPress   = StDebPressEnc,
    StPulse      = StPulseEnc,
    StHeld       = StHeldEnc,
    StDebRelease = StDebReleaseEnc
  } load_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset; both flops load ResetVal
//   d_i    - asynchronous input
//   q_o    - synchronised output (two clk_i edges of latency)
module sync_2ff #(
  parameter bit ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/load_pulse_gen.sv
// Load strobe generator for the display load registers.
// Synchronises and debounces an active-low pushbutton and issues one single-cycle Load_out
// pulse per confirmed press, keeping a wrapping 8-bit count of issued loads.
// Optional feature macro: LOAD_AUTO_REPEAT_EN - while the button stays held, issue a further
// load every REPEAT_CYCLES cycles of HELD (plus the PULSE cycle).
// Ports:
//   Clock      - system clock, posedge
//   Reset      - asynchronous active-low reset, clears all state
//   Button_in  - raw pushbutton, active-low, asynchronous to Clock
//   Enable     - presses may start a load only while this is high (sampled in IDLE)
//   Load_out   - registered single-cycle load strobe
//   Busy       - registered, high whenever the FSM is not idle
//   Load_count - registered count of Load_out pulses, wraps 255 -> 0
module load_pulse_gen
  import load_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned REPEAT_CYCLES   = DefaultRepeatCycles
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Button_in,
  input  logic       Enable,
  output logic       Load_out,
  output logic       Busy,
  output logic [7:0] Load_count
);

  // A zero interval could never be matched by its counter; treat it as a dead debouncer.
  localparam bit ParamsOk = (DEBOUNCE_CYCLES >= 1) && (REPEAT_CYCLES >= 1);
  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;
  logic pressed;

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .d_i    (Button_in),
    .q_o    (btn_s)
  );

  assign pressed = ~btn_s;

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_done;
  logic             load_q;
  logic             busy_q;
  logic [7:0]       count_q;

  assign deb_done = ParamsOk && (cnt_q == DebLast);

`ifdef LOAD_AUTO_REPEAT_EN
  // Sized from the interval itself so the (large) default repeat period always fits.
  localparam int unsigned RepW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

  logic [RepW-1:0] rep_q, rep_d;
  logic            rep_done;

  assign rep_done = (rep_q == RepLast);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef LOAD_AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pressed && Enable) begin
          state_d = StDebPress;
          cnt_d   = '0;
        end
      end
      StDebPress: begin
        if (!pressed) begin
          state_d = StIdle;
        end else if (deb_done) begin
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPulse: begin
        state_d = StHeld;
        cnt_d   = '0;
`ifdef LOAD_AUTO_REPEAT_EN
        rep_d   = '0;
`endif
      end
      StHeld: begin
        if (!pressed) begin
          state_d = StDebRelease;
          cnt_d   = '0;
`ifdef LOAD_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
`ifdef LOAD_AUTO_REPEAT_EN
          if (rep_done) begin
            state_d = StPulse;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + RepW'(1);
          end
`endif
        end
      end
      StDebRelease: begin
        if (pressed) begin
          // Release bounce: fall back to HELD without issuing a new load.
          state_d = StHeld;
          cnt_d   = '0;
        end else if (deb_done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so Load_out coincides with state == PULSE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= (state_d == StPulse);
      busy_q  <= (state_d != StIdle);
      if (state_d == StPulse) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign Load_out   = load_q;
  assign Busy       = busy_q;
  assign Load_count = count_q;

endmodule

// File: tb/tb_load_pulse_gen.sv
// Scoreboard bench for load_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Inputs change just after the falling edge; a press first captured at posedge t must give
// a pulse visible after posedge t+6, carrying the next Load_count value.
module tb_load_pulse_gen;

  logic       Clock;
  logic       Reset;
  logic       Button_in;
  logic       Enable;
  logic       Load_out;
  logic       Busy;
  logic [7:0] Load_count;

  load_pulse_gen #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16),
    .REPEAT_CYCLES   (8)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Button_in  (Button_in),
    .Enable     (Enable),
    .Load_out   (Load_out),
    .Busy       (Busy),
    .Load_count (Load_count)
  );

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   exp_count = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c);
    exp_count = (exp_count + 1) % 256;
    exp_q.push_back('{c, exp_count});
  endtask

  task automatic press(input int n);
    Button_in = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  task automatic rel(input int n);
    Button_in = 1'b1;
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge Clock) begin
    if (Reset && Load_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d count %0d, required none",
                 cyc, Load_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_count", int'(Load_count), e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int s;
    int busy_seen;
    Reset     = 1'b0;
    Button_in = 1'b0;
    Enable    = 1'b1;
    repeat (3) @(negedge Clock);
    check("reset_load_out", int'(Load_out), 0);
    check("reset_busy", int'(Busy), 0);
    check("reset_count", int'(Load_count), 0);

    // 1: button already held when reset releases
    Reset = 1'b1;
    t = cyc + 1;
    push(t + 6);
    press(8);
    rel(12);
    check("t1_count", int'(Load_count), 1);
    check("t1_busy_idle", int'(Busy), 0);

    // 2: 2-cycle bounces then stable press
    press(2); rel(2); press(2); rel(2);
    s = cyc + 1;
    push(s + 6);
    press(8);
    rel(12);
    check("t2_count", int'(Load_count), 2);

    // 3: long press, bouncy release, re-press after 5 stable released cycles
    t = cyc + 1;
    push(t + 6);
`ifdef LOAD_AUTO_REPEAT_EN
    push(t + 15);
`endif
    press(20);
    rel(2);
    press(2);
    rel(5);
    s = cyc + 1;
    push(s + 6);
    press(8);
    rel(12);
    check("t3_count", int'(Load_count), exp_count);

    // 4a: Enable low in IDLE ignores a full press
    Enable    = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      Button_in = (i < 8) ? 1'b0 : 1'b1;
      @(negedge Clock);
      if (Busy) busy_seen++;
    end
    check("t4_busy_enable_low", busy_seen, 0);
    check("t4_count_enable_low", int'(Load_count), exp_count);

    // 4b: Enable dropped during DEB_PRESS still pulses
    Enable = 1'b1;
    t = cyc + 1;
    push(t + 6);
    press(3);
    Enable = 1'b0;
    press(5);
    rel(12);
    Enable = 1'b1;
    check("t4_count_enable_drop", int'(Load_count), exp_count);

    // 5a: fresh reset, then 256 presses wrap the count back to zero
    Reset = 1'b0;
    #1;
    check("t5_reset_count", int'(Load_count), 0);
    exp_count = 0;
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      t = cyc + 1;
      push(t + 6);
      press(6);
      rel(6);
    end
    check("t5_wrap_count", int'(Load_count), 0);

    // 5b: asynchronous reset mid-debounce aborts without a pulse
    press(4);
    check("t5_busy_in_debounce", int'(Busy), 1);
    #2;
    Reset = 1'b0;
    #1;
    check("t5_async_load_out", int'(Load_out), 0);
    check("t5_async_busy", int'(Busy), 0);
    check("t5_async_count", int'(Load_count), 0);
    exp_count = 0;
    @(negedge Clock);
    Reset = 1'b1;
    t = cyc + 1;
    push(t + 6);
    press(8);
    rel(12);
    check("t5_count_after_reset", int'(Load_count), 1);

    // 6: hold well past the first pulse; repeats only with the auto-repeat build
    t = cyc + 1;
    push(t + 6);
`ifdef LOAD_AUTO_REPEAT_EN
    push(t + 15);
    push(t + 24);
    push(t + 33);
`endif
    press(36);
    rel(12);
    check("t6_count", int'(Load_count), exp_count);

    repeat (4) @(negedge Clock);
    check("pending_pulses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
